// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller for the 5-stage pipeline.
// Decodes per-stage stall requests into stage-register enables and flushes.
// Issues the exception/ERET fetch redirect, deferring it while a fetch is
// outstanding, and counts stall cycles for performance monitoring.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             exc_valid,
  input  logic             exc_is_eret,
  input  logic [31:0]      cp0_epc,
  output logic             en_pc,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    WAIT_IF = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        tgt_q, tgt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        exc_tgt_s;
  logic               any_stall_s;

  assign exc_tgt_s   = exc_is_eret ? cp0_epc : EXC_VECTOR;
  assign any_stall_s = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;
  assign stall_cnt   = cnt_q;

  // State, pending redirect target and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q   <= 32'h0000_0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and combinational en/flush/redirect decode.
  always_comb begin
    state_d        = state_q;
    tgt_d          = tgt_q;
    cnt_d          = cnt_q;
    en_pc          = 1'b1;
    en_if_id       = 1'b1;
    en_id_ex       = 1'b1;
    en_ex_mem      = 1'b1;
    en_mem_wb      = 1'b1;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    flush_ex_mem   = 1'b0;
    flush_mem_wb   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;

    if (rst) begin
      // Hold every stage and clear its contents; a pending redirect is dropped.
      en_pc        = 1'b0;
      en_if_id     = 1'b0;
      en_id_ex     = 1'b0;
      en_ex_mem    = 1'b0;
      en_mem_wb    = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
      state_d      = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (exc_valid) begin
            // Kill everything in flight; the flush makes the matching en a don't-care (1).
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
            if (stallreq_if) begin
              en_pc   = 1'b0;
              tgt_d   = exc_tgt_s;
              state_d = WAIT_IF;
            end else begin
              redirect_valid = 1'b1;
              redirect_pc    = exc_tgt_s;
            end
          end else begin
            if (any_stall_s) begin
              cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              cnt_d = cnt_q;
            end
            // Freeze everything up to the highest stalled stage, bubble the next one.
            if (stallreq_mem) begin
              en_pc        = 1'b0;
              en_if_id     = 1'b0;
              en_id_ex     = 1'b0;
              en_ex_mem    = 1'b0;
              flush_mem_wb = 1'b1;
            end else if (stallreq_ex) begin
              en_pc        = 1'b0;
              en_if_id     = 1'b0;
              en_id_ex     = 1'b0;
              flush_ex_mem = 1'b1;
            end else if (stallreq_id) begin
              en_pc       = 1'b0;
              en_if_id    = 1'b0;
              flush_id_ex = 1'b1;
            end else if (stallreq_if) begin
              en_pc       = 1'b0;
              flush_if_id = 1'b1;
            end else begin
              en_pc = 1'b1;
            end
          end
        end
        WAIT_IF: begin
          // Keep the pipe empty until the outstanding fetch completes.
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          flush_mem_wb = 1'b1;
          if (stallreq_if) begin
            en_pc = 1'b0;
          end else begin
            redirect_valid = 1'b1;
            redirect_pc    = tgt_q;
            state_d        = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

endmodule
